// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU definitions: command encodings, controller states, result
// bundle and default latencies for the multiply/divide sequencer.
package mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 8;

    // wr is cleared when the operation must leave HI/LO untouched (divide by zero)
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        wr;
    } mdu_result_t;

    function automatic logic is_arith(logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// E/D-stage side of the MDU: command inputs, stall/busy and HI/LO results.
interface mdu_ctrl_if;

    logic        start;
    logic [3:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_is_md;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_rdata;

    modport master (
        output start, md_op, rs_val, rt_val, d_is_md,
        input  busy, stall_md, hi, lo, md_rdata
    );

    modport slave (
        input  start, md_op, rs_val, rt_val, d_is_md,
        output busy, stall_md, hi, lo, md_rdata
    );

endinterface

// File: rtl/mdu_arith.sv
// Combinational 64-bit result for MULT/MULTU/DIV/DIVU, including the
// divide-by-zero (no write) and INT_MIN / -1 overflow rules.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output mdu_result_t res_o
);

    logic signed [63:0] smul;
    logic        [63:0] umul;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    logic        [31:0] uq;
    logic        [31:0] ur;
    logic        [31:0] div_b;
    logic               div_zero;
    logic               div_ovf;

    // Divisor is forced to 1 on zero so the dividers never see an undefined case
    always_comb begin
        div_zero = (b_i == 32'd0);
        div_b    = div_zero ? 32'd1 : b_i;
        div_ovf  = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
        smul     = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
        umul     = {32'd0, a_i} * {32'd0, b_i};
        uq       = a_i / div_b;
        ur       = a_i % div_b;
        if (div_ovf) begin
            sq = 32'sh8000_0000;
            sr = 32'sd0;
        end else begin
            sq = $signed(a_i) / $signed(div_b);
            sr = $signed(a_i) % $signed(div_b);
        end

        res_o = '0;
        case (op_i)
            MD_MULT:  res_o = '{hi: smul[63:32], lo: smul[31:0], wr: 1'b1};
            MD_MULTU: res_o = '{hi: umul[63:32], lo: umul[31:0], wr: 1'b1};
            MD_DIV:   res_o = '{hi: sr, lo: sq, wr: !div_zero};
            MD_DIVU:  res_o = '{hi: ur, lo: uq, wr: !div_zero};
            default:  res_o = '0;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: fixed-latency busy counter, HI/LO registers
// and the D-stage stall request for the shared MDU.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    mdu_ctrl_if.slave   bus
);

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    mdu_result_t       pend_q, pend_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    mdu_result_t       arith_res;

    mdu_arith u_arith (
        .op_i  (bus.md_op),
        .a_i   (bus.rs_val),
        .b_i   (bus.rt_val),
        .res_o (arith_res)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Commands are only accepted in IDLE; anything issued during RUN is dropped
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (is_arith(bus.md_op)) begin
                        pend_d  = arith_res;
                        state_d = ST_RUN;
                        if ((bus.md_op == MD_DIV) || (bus.md_op == MD_DIVU)) begin
                            cnt_d = CNT_W'(DIV_CYCLES);
                        end else begin
                            cnt_d = CNT_W'(MULT_CYCLES);
                        end
                    end else if (bus.md_op == MD_MTHI) begin
                        hi_d = bus.rs_val;
                    end else if (bus.md_op == MD_MTLO) begin
                        lo_d = bus.rs_val;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    if (pend_q.wr) begin
                        hi_d = pend_q.hi;
                        lo_d = pend_q.lo;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.busy     = (state_q == ST_RUN);
    assign bus.stall_md = bus.d_is_md & (bus.busy | (bus.start & is_arith(bus.md_op)));
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

    always_comb begin
        bus.md_rdata = 32'd0;
        if (bus.md_op == MD_MFHI) begin
            bus.md_rdata = hi_q;
        end else if (bus.md_op == MD_MFLO) begin
            bus.md_rdata = lo_q;
        end
    end

endmodule
